// File: rtl/sprite_pkg.sv
// Shared types for the sprite renderer: OAM and secondary-array entry layouts,
// FSM states, and sprite geometry constants.
package sprite_pkg;

  localparam int         SPRITE_SIZE     = 16;
  localparam logic [7:0] TRANSPARENT_IDX = 8'd0;

  // Low 28 bits of an OAM word; the top nibble is reserved.
  typedef struct packed {
    logic       hflip;
    logic [7:0] tile;
    logic [8:0] y;
    logic [9:0] x;
  } oam_entry_t;

  typedef struct packed {
    logic [7:0] oam_addr;
    logic       active;
  } second_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_OAM_WAIT,
    ST_VRAM_WAIT,
    ST_DRAW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sprite_palette.sv
// Fixed RGB332 palette: expands an 8-bit colour index to 24-bit RGB by bit
// replication so full-scale channel codes reach 0xFF.
module sprite_palette (
  input  logic [7:0]  idx_i,
  output logic [23:0] rgb_o
);

  assign rgb_o = {idx_i[7:5], idx_i[7:5], idx_i[7:6],
                  idx_i[4:2], idx_i[4:2], idx_i[4:3],
                  {4{idx_i[1:0]}}};

endmodule

// File: rtl/sprite_drawer.sv
// Per-scanline sprite renderer: walks the secondary sprite array from the last
// entry down, fetches OAM then VRAM rows, and paints opaque pixels into a line
// buffer. Define SPRITE_HFLIP_EN to honour the OAM horizontal-flip bit.
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int VRAM_ADDR_SIZE    = 12,
  parameter int VRAM_DATA_SIZE    = 128,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int COLOR_DEPTH       = 8,
  parameter int PALETTE_SIZE      = 256,
  parameter int DISPLAY_WIDTH     = 600,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           enable,
  output logic                                           done,
  output logic [OAM_ADDR_SIZE-1:0]                       oam_a,
  input  logic [OAM_DATA_SIZE-1:0]                       oam_d,
  output logic [VRAM_ADDR_SIZE-1:0]                      vram_a,
  input  logic [VRAM_DATA_SIZE-1:0]                      vram_d,
  input  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]  second_array,
  input  logic [LINE_NUMBER_WIDTH-1:0]                   line_number,
  output logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] line_buffer
);

  localparam int IDX_W = $clog2(SECOND_ARRAY_SIZE);
  localparam int PIX_W = $clog2(PALETTE_SIZE);
  localparam int POS_W = $clog2(DISPLAY_WIDTH) + 1;
  localparam int ROW_W = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECOND_ARRAY_SIZE - 1);

  typedef logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] line_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      done_q;
  logic [OAM_ADDR_SIZE-1:0]  oam_a_q;
  logic [VRAM_ADDR_SIZE-1:0] vram_a_q;
  logic [9:0]                x_q;
  line_t                     line_q;
`ifdef SPRITE_HFLIP_EN
  logic                      hflip_q;
`endif

  second_entry_t entry;
  oam_entry_t    oam;
  logic [ROW_W-1:0] row;
  logic          on_line;
  logic          advance;
  line_t         draw_buf;

  logic [SPRITE_SIZE-1:0][PIX_W-1:0]          pix_idx;
  logic [SPRITE_SIZE-1:0][2:0][COLOR_DEPTH-1:0] pix_rgb;

  assign entry   = second_array[idx_q];
  assign oam     = oam_entry_t'(oam_d[27:0]);
  assign row     = ROW_W'(line_number) - ROW_W'(oam.y);
  assign on_line = (ROW_W'(oam.y) <= ROW_W'(line_number)) && (row < ROW_W'(SPRITE_SIZE));

  // Reserved OAM bits and the frame height play no part in drawing one line.
  logic unused_bits;
`ifdef SPRITE_HFLIP_EN
  assign unused_bits = ^{oam_d[OAM_DATA_SIZE-1:28], DISPLAY_HEIGHT[0]};
`else
  assign unused_bits = ^{oam_d[OAM_DATA_SIZE-1:28], oam.hflip, DISPLAY_HEIGHT[0]};
`endif

  assign pix_idx = vram_d;

  for (genvar g = 0; g < SPRITE_SIZE; g++) begin : g_pal
    sprite_palette u_pal (
      .idx_i (pix_idx[g]),
      .rgb_o (pix_rgb[g])
    );
  end

  // Overlay the fetched row onto the current buffer, clipping at the right edge.
  always_comb begin : draw_merge
    logic [POS_W-1:0] pos;
    int               offset;
    draw_buf = line_q;
    pos      = '0;
    offset   = 0;
    for (int i = 0; i < SPRITE_SIZE; i++) begin
`ifdef SPRITE_HFLIP_EN
      offset = hflip_q ? (SPRITE_SIZE - 1 - i) : i;
`else
      offset = i;
`endif
      pos = POS_W'(x_q) + POS_W'(offset);
      if (pix_idx[i] != TRANSPARENT_IDX && pos < POS_W'(DISPLAY_WIDTH))
        draw_buf[pos[POS_W-2:0]] = pix_rgb[i];
    end
  end

  // Cycles that finish with the current entry and move to the next one.
  always_comb begin
    advance = 1'b0;
    case (state_q)
      ST_SCAN:     advance = !entry.active;
      ST_OAM_WAIT: advance = !on_line;
      ST_DRAW:     advance = 1'b1;
      default:     advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= LAST_IDX;
      done_q   <= 1'b0;
      oam_a_q  <= '0;
      vram_a_q <= '0;
      x_q      <= '0;
      // NOTE: the line buffer is plain flops, not a RAM macro, so it can and must reset.
      line_q   <= '0;
`ifdef SPRITE_HFLIP_EN
      hflip_q  <= 1'b0;
`endif
    end else if (!enable && state_q != ST_IDLE) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          line_q  <= '0;
          idx_q   <= LAST_IDX;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (entry.active) begin
            oam_a_q <= entry.oam_addr;
            state_q <= ST_OAM_WAIT;
          end
        end
        ST_OAM_WAIT: begin
          if (on_line) begin
            vram_a_q <= VRAM_ADDR_SIZE'({oam.tile, row[3:0]});
            x_q      <= oam.x;
`ifdef SPRITE_HFLIP_EN
            hflip_q  <= oam.hflip;
`endif
            state_q  <= ST_VRAM_WAIT;
          end
        end
        ST_VRAM_WAIT: state_q <= ST_DRAW;
        ST_DRAW:      line_q  <= draw_buf;
        ST_DONE:      done_q  <= 1'b1;
        default:      state_q <= ST_IDLE;
      endcase

      if (advance) begin
        if (idx_q == '0) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end else begin
          idx_q   <= idx_q - IDX_W'(1);
          state_q <= ST_SCAN;
        end
      end
    end
  end

  assign done        = done_q;
  assign oam_a       = oam_a_q;
  assign vram_a      = vram_a_q;
  assign line_buffer = line_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Self-checking bench for sprite_drawer: a scanline reference model plus
// directed scenarios with hand-computed pixel, address and latency values.
module tb_sprite_drawer;

`ifdef SPRITE_HFLIP_EN
  localparam bit HFLIP = 1'b1;
`else
  localparam bit HFLIP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   done;
  logic [7:0]             oam_a;
  logic [31:0]            oam_d;
  logic [11:0]            vram_a;
  logic [127:0]           vram_d;
  logic [31:0][8:0]       second_array;
  logic [9:0]             line_number;
  logic [599:0][2:0][7:0] line_buffer;

  logic [31:0]  oam_mem  [256];
  logic [127:0] vram_mem [4096];

  logic [23:0] exp_buf [600];
  int          exp_cycles;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // The DUT's registered address is the RAM's address stage: data follows it.
  assign oam_d  = oam_mem[oam_a];
  assign vram_d = vram_mem[vram_a];

  sprite_drawer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .done         (done),
    .oam_a        (oam_a),
    .oam_d        (oam_d),
    .vram_a       (vram_a),
    .vram_d       (vram_d),
    .second_array (second_array),
    .line_number  (line_number),
    .line_buffer  (line_buffer)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_px(input string name, input int p, input logic [23:0] exp);
    check($sformatf("%s px%0d", name, p), 64'(line_buffer[p]), 64'(exp));
  endtask

  // RGB332 expanded to 8 bits per channel, as nearest-integer scaling.
  function automatic logic [23:0] model_rgb(input int p);
    int r, g, b;
    r = (p >> 5) & 7;
    g = (p >> 2) & 7;
    b = p & 3;
    return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
  endfunction

  // Paint the whole line from the memories; also total the expected latency.
  function automatic void model_render(input logic [31:0][8:0] s, input int line);
    logic [31:0]  w;
    logic [127:0] px_row;
    int x, y, tile, row, p, pos;
    bit hf;
    for (int k = 0; k < 600; k++) exp_buf[k] = 24'h0;
    exp_cycles = 2;
    for (int e = 31; e >= 0; e--) begin
      if (!s[e][0]) begin
        exp_cycles += 1;
        continue;
      end
      w    = oam_mem[s[e][8:1]];
      x    = int'(w[9:0]);
      y    = int'(w[18:10]);
      tile = int'(w[26:19]);
      hf   = HFLIP && w[27];
      row  = line - y;
      if (row < 0 || row >= 16) begin
        exp_cycles += 2;
        continue;
      end
      exp_cycles += 4;
      px_row = vram_mem[tile * 16 + row];
      for (int i = 0; i < 16; i++) begin
        p   = int'(px_row[8*i +: 8]);
        pos = hf ? (x + 15 - i) : (x + i);
        if (p != 0 && pos < 600) exp_buf[pos] = model_rgb(p);
      end
    end
  endfunction

  always @(negedge clk) begin : compare
    int bad;
    if (chk_en && done) begin
      bad = -1;
      for (int k = 599; k >= 0; k--)
        if (line_buffer[k] !== exp_buf[k]) bad = k;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL line_buffer vs model: pixel %0d got %h, expected %h",
                 bad, line_buffer[bad], exp_buf[bad]);
      end
    end
  end

  task automatic clear_setup();
    second_array = '0;
    for (int i = 0; i < 256; i++)  oam_mem[i]  = '0;
    for (int i = 0; i < 4096; i++) vram_mem[i] = '0;
  endtask

  task automatic set_oam(input int a, input int x, input int y, input int tile, input bit hf);
    oam_mem[a] = {4'h0, hf, 8'(tile), 9'(y), 10'(x)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_line(input string name, input int line, input int lit_cycles);
    int n;
    @(negedge clk);
    line_number = 10'(line);
    model_render(second_array, line);
    check({name, " model latency"}, 64'(exp_cycles), 64'(lit_cycles));
    chk_en = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 2000);
    check({name, " edges to done"}, 64'(n), 64'(exp_cycles));
    repeat (2) @(negedge clk);
  endtask

  task automatic end_line(input string name);
    @(negedge clk);
    enable = 1'b0;
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    check({name, " done after enable low"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    enable       = 1'b0;
    line_number  = '0;
    clear_setup();
    do_reset();
    check("reset done",   64'(done),         64'd0);
    check("reset oam_a",  64'(oam_a),        64'd0);
    check("reset vram_a", 64'(vram_a),       64'd0);
    check("reset buffer", 64'(|line_buffer), 64'd0);

    // All entries inactive.
    run_line("empty", 0, 34);
    check("empty oam_a",  64'(oam_a),        64'd0);
    check("empty vram_a", 64'(vram_a),       64'd0);
    check("empty buffer", 64'(|line_buffer), 64'd0);
    end_line("empty");

    // One red sprite at x=100 on line 3.
    clear_setup();
    do_reset();
    second_array[0] = {8'd5, 1'b1};
    set_oam(5, 100, 0, 2, 1'b0);
    vram_mem[12'h023] = {16{8'hE0}};
    run_line("basic", 3, 37);
    check("basic oam_a",  64'(oam_a),  64'd5);
    check("basic vram_a", 64'(vram_a), 64'h023);
    check_px("basic", 100, 24'hFF0000);
    check_px("basic", 115, 24'hFF0000);
    check_px("basic", 99,  24'h000000);
    check_px("basic", 116, 24'h000000);
    end_line("basic");

    // Same sprite but below the line: no VRAM fetch.
    clear_setup();
    do_reset();
    second_array[0] = {8'd5, 1'b1};
    set_oam(5, 100, 10, 2, 1'b0);
    vram_mem[12'h023] = {16{8'hE0}};
    run_line("offline", 3, 35);
    check("offline vram_a", 64'(vram_a),       64'd0);
    check("offline buffer", 64'(|line_buffer), 64'd0);
    end_line("offline");

    // Right-edge clipping.
    clear_setup();
    do_reset();
    second_array[0] = {8'd5, 1'b1};
    set_oam(5, 590, 0, 2, 1'b0);
    vram_mem[12'h023] = {16{8'h1C}};
    run_line("clip", 3, 37);
    check_px("clip", 590, 24'h00FF00);
    check_px("clip", 599, 24'h00FF00);
    check_px("clip", 589, 24'h000000);
    check_px("clip", 0,   24'h000000);
    check_px("clip", 5,   24'h000000);
    end_line("clip");

    // Overlap priority and transparency.
    clear_setup();
    do_reset();
    second_array[1] = {8'd6, 1'b1};
    second_array[0] = {8'd5, 1'b1};
    set_oam(6, 50, 0, 3, 1'b0);
    set_oam(5, 50, 0, 2, 1'b0);
    vram_mem[12'h033] = {16{8'h03}};
    vram_mem[12'h023] = {{15{8'h1C}}, 8'h00};
    run_line("overlap", 3, 40);
    check_px("overlap", 50, 24'h0000FF);
    check_px("overlap", 51, 24'h00FF00);
    check_px("overlap", 65, 24'h00FF00);
    check_px("overlap", 66, 24'h000000);
    end_line("overlap");

    // Horizontal flip bit: only mirrors when the feature is built in.
    clear_setup();
    do_reset();
    second_array[0] = {8'd5, 1'b1};
    set_oam(5, 200, 0, 2, 1'b1);
    vram_mem[12'h023] = {120'h0, 8'hE0};
    run_line("hflip", 3, 37);
`ifdef SPRITE_HFLIP_EN
    check_px("hflip", 215, 24'hFF0000);
    check_px("hflip", 200, 24'h000000);
`else
    check_px("hflip", 200, 24'hFF0000);
    check_px("hflip", 215, 24'h000000);
`endif
    end_line("hflip");

    // Abort by dropping enable after entry 31 is drawn but before entry 0.
    clear_setup();
    do_reset();
    second_array[31] = {8'd7, 1'b1};
    second_array[0]  = {8'd5, 1'b1};
    set_oam(7, 300, 0, 4, 1'b0);
    set_oam(5, 100, 0, 2, 1'b0);
    vram_mem[12'h043] = {16{8'hE0}};
    vram_mem[12'h023] = {16{8'h03}};
    @(negedge clk);
    line_number = 10'd3;
    enable      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort done", 64'(done), 64'd0);
    check_px("abort", 300, 24'hFF0000);
    check_px("abort", 315, 24'hFF0000);
    check_px("abort", 100, 24'h000000);
    repeat (40) @(posedge clk);
    #1;
    check("abort stays idle done", 64'(done), 64'd0);
    check_px("abort stays idle", 100, 24'h000000);

    // Reset in the middle of a line.
    @(negedge clk);
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_px("pre-reset", 300, 24'hFF0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset done",   64'(done),         64'd0);
    check("midreset buffer", 64'(|line_buffer), 64'd0);
    check("midreset oam_a",  64'(oam_a),        64'd0);
    check("midreset vram_a", 64'(vram_a),       64'd0);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset idle done", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
